// File: rtl/dm_store_buffer.sv
// dm_store_buffer
//   Store buffer that sits between the MEM-stage store path and the data memory
//   write port. It queues up to DEPTH word stores and retires them to dm in
//   order, one per cycle, whenever the dm port is free. Loads look up the
//   buffer for read-after-write forwarding. A store to the same word as the
//   youngest entry is merged into that entry instead of taking a new slot.
//
// Ports
//   Clk                 clock, all state updates on posedge
//   Reset               asynchronous, active-low reset
//   St_Valid/Addr/WD/PC store request from MEM (word index = St_Addr[31:2])
//   St_Ready            store accepted this cycle when St_Valid=1
//   Ld_Addr             load address for the forwarding lookup
//   Ld_Hit/Ld_Data      youngest matching entry (data is 0 when no hit)
//   Dm_Busy             dm port claimed by someone else this cycle
//   Dm_WE/Addr/WD/PC    head-entry retire to dm (all 0 when empty)
//   Empty/Count         occupancy
module dm_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       St_Valid,
    input  logic [31:0]                St_Addr,
    input  logic [31:0]                St_WD,
    input  logic [31:0]                St_PC,
    output logic                       St_Ready,
    input  logic [31:0]                Ld_Addr,
    output logic                       Ld_Hit,
    output logic [31:0]                Ld_Data,
    input  logic                       Dm_Busy,
    output logic                       Dm_WE,
    output logic [31:0]                Dm_Addr,
    output logic [31:0]                Dm_WD,
    output logic [31:0]                Dm_PC,
    output logic                       Empty,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [29:0]   ent_addr [DEPTH];
    logic [31:0]   ent_data [DEPTH];
    logic [31:0]   ent_pc   [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] tail_m1;
    logic [CW-1:0] count;

    logic empty;
    logic pop;
    logic coal;
    logic push;

    // Byte offsets never matter: the buffer works on whole words.
    logic unused_byte_bits;
    assign unused_byte_bits = ^{St_Addr[1:0], Ld_Addr[1:0]};

    assign tail_m1 = tail - 1'b1;
    assign empty   = (count == '0);
    assign pop     = !empty && !Dm_Busy;

    // Merging into the youngest entry is not allowed when it is also the head
    // being retired right now: the merged data would miss the dm write.
    assign coal = St_Valid && !empty
               && (St_Addr[31:2] == ent_addr[tail_m1])
               && !((count == CW'(1)) && pop);

    // A pop in the same cycle does not free a slot for the push.
    assign St_Ready = (count < CW'(DEPTH)) || coal;
    assign push     = St_Valid && St_Ready && !coal;

    assign Dm_WE   = pop;
    assign Dm_Addr = empty ? 32'd0 : {ent_addr[head], 2'b00};
    assign Dm_WD   = empty ? 32'd0 : ent_data[head];
    assign Dm_PC   = empty ? 32'd0 : ent_pc[head];
    assign Empty   = empty;
    assign Count   = count;

    // Walk from head (oldest) towards tail so the last match is the youngest.
    always_comb begin
        Ld_Hit  = 1'b0;
        Ld_Data = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count) && (ent_addr[head + PW'(i)] == Ld_Addr[31:2])) begin
                Ld_Hit  = 1'b1;
                Ld_Data = ent_data[head + PW'(i)];
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
                ent_pc[i]   <= '0;
            end
        end else begin
            if (push) begin
                ent_addr[tail] <= St_Addr[31:2];
                ent_data[tail] <= St_WD;
                ent_pc[tail]   <= St_PC;
                tail           <= tail + 1'b1;
            end else if (coal) begin
                ent_data[tail_m1] <= St_WD;
                ent_pc[tail_m1]   <= St_PC;
            end

            if (pop) begin
                head <= head + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer
//   Directed bench for dm_store_buffer. Inputs change 1 time unit after each
//   rising edge; outputs are sampled before the next rising edge.
module tb_dm_store_buffer;

    logic        Clk;
    logic        Reset;
    logic        St_Valid;
    logic [31:0] St_Addr;
    logic [31:0] St_WD;
    logic [31:0] St_PC;
    logic        St_Ready;
    logic [31:0] Ld_Addr;
    logic        Ld_Hit;
    logic [31:0] Ld_Data;
    logic        Dm_Busy;
    logic        Dm_WE;
    logic [31:0] Dm_Addr;
    logic [31:0] Dm_WD;
    logic [31:0] Dm_PC;
    logic        Empty;
    logic [2:0]  Count;

    int n_checks = 0;
    int n_errors = 0;

    dm_store_buffer #(.DEPTH(4)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .St_Valid (St_Valid),
        .St_Addr  (St_Addr),
        .St_WD    (St_WD),
        .St_PC    (St_PC),
        .St_Ready (St_Ready),
        .Ld_Addr  (Ld_Addr),
        .Ld_Hit   (Ld_Hit),
        .Ld_Data  (Ld_Data),
        .Dm_Busy  (Dm_Busy),
        .Dm_WE    (Dm_WE),
        .Dm_Addr  (Dm_Addr),
        .Dm_WD    (Dm_WD),
        .Dm_PC    (Dm_PC),
        .Empty    (Empty),
        .Count    (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        St_Valid = 1'b1;
        St_Addr  = a;
        St_WD    = d;
        St_PC    = 32'h1000_0000 | a;
        tick();
        St_Valid = 1'b0;
    endtask

    initial begin
        Reset    = 1'b0;
        St_Valid = 1'b0;
        St_Addr  = 32'd0;
        St_WD    = 32'd0;
        St_PC    = 32'd0;
        Ld_Addr  = 32'd0;
        Dm_Busy  = 1'b0;

        // 1: reset state
        tick();
        tick();
        check_eq("rst_empty", 32'(Empty), 32'd1);
        check_eq("rst_count", 32'(Count), 32'd0);
        check_eq("rst_dm_we", 32'(Dm_WE), 32'd0);
        check_eq("rst_st_ready", 32'(St_Ready), 32'd1);
        check_eq("rst_ld_hit", 32'(Ld_Hit), 32'd0);
        Reset = 1'b1;
        tick();

        // 2: single store retires next cycle, no same-cycle bypass
        Dm_Busy  = 1'b0;
        St_Valid = 1'b1;
        St_Addr  = 32'h10;
        St_WD    = 32'hDEAD_BEEF;
        St_PC    = 32'h0000_0400;
        Ld_Addr  = 32'h10;
        #1;
        check_eq("t2_no_bypass_we", 32'(Dm_WE), 32'd0);
        check_eq("t2_no_bypass_hit", 32'(Ld_Hit), 32'd0);
        tick();
        St_Valid = 1'b0;
        #1;
        check_eq("t2_dm_we", 32'(Dm_WE), 32'd1);
        check_eq("t2_dm_addr", Dm_Addr, 32'h10);
        check_eq("t2_dm_wd", Dm_WD, 32'hDEAD_BEEF);
        check_eq("t2_dm_pc", Dm_PC, 32'h0000_0400);
        check_eq("t2_fwd_retiring", Ld_Data, 32'hDEAD_BEEF);
        tick();
        check_eq("t2_empty", 32'(Empty), 32'd1);
        check_eq("t2_dm_addr_empty", Dm_Addr, 32'd0);

        // 3: fill while busy, full refusal, in-order drain
        Dm_Busy = 1'b1;
        for (int i = 0; i < 4; i++) store(32'(4 * i), 32'h100 + 32'(i));
        check_eq("t3_count_full", 32'(Count), 32'd4);
        St_Valid = 1'b1;
        St_Addr  = 32'h20;
        St_WD    = 32'h55;
        #1;
        check_eq("t3_full_refuse", 32'(St_Ready), 32'd0);
        // Pop in the same cycle must not open a slot for the push.
        Dm_Busy = 1'b0;
        #1;
        check_eq("t3_full_pop_refuse", 32'(St_Ready), 32'd0);
        St_Valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t3_dm_we_%0d", i), 32'(Dm_WE), 32'd1);
            check_eq($sformatf("t3_dm_addr_%0d", i), Dm_Addr, 32'(4 * i));
            check_eq($sformatf("t3_dm_wd_%0d", i), Dm_WD, 32'h100 + 32'(i));
            tick();
        end
        check_eq("t3_empty", 32'(Empty), 32'd1);
        check_eq("t3_dm_we_off", 32'(Dm_WE), 32'd0);

        // 4: forwarding picks the youngest match
        Dm_Busy = 1'b1;
        store(32'h8, 32'h11);
        store(32'hC, 32'h22);
        store(32'h8, 32'h33);
        check_eq("t4_count", 32'(Count), 32'd3);
        Ld_Addr = 32'h8;
        #1;
        check_eq("t4_hit_8", 32'(Ld_Hit), 32'd1);
        check_eq("t4_data_8", Ld_Data, 32'h33);
        Ld_Addr = 32'hA;
        #1;
        check_eq("t4_hit_a", 32'(Ld_Hit), 32'd1);
        check_eq("t4_data_a", Ld_Data, 32'h33);
        Ld_Addr = 32'hC;
        #1;
        check_eq("t4_data_c", Ld_Data, 32'h22);
        Ld_Addr = 32'h10;
        #1;
        check_eq("t4_hit_10", 32'(Ld_Hit), 32'd0);
        check_eq("t4_data_10", Ld_Data, 32'd0);
        Dm_Busy = 1'b0;
        tick();
        tick();
        tick();
        check_eq("t4_drained", 32'(Empty), 32'd1);

        // 5a: back-to-back same word merges into one entry
        Dm_Busy = 1'b1;
        store(32'h4, 32'hA);
        store(32'h4, 32'hB);
        check_eq("t5_count_merge", 32'(Count), 32'd1);
        Dm_Busy = 1'b0;
        #1;
        check_eq("t5_dm_wd", Dm_WD, 32'hB);
        check_eq("t5_dm_pc", Dm_PC, 32'h1000_0004);
        tick();
        check_eq("t5_single_write", 32'(Dm_WE), 32'd0);

        // 5b: merge accepted while full
        Dm_Busy = 1'b1;
        for (int i = 0; i < 4; i++) store(32'h40 + 32'(4 * i), 32'h200 + 32'(i));
        St_Valid = 1'b1;
        St_Addr  = 32'h4C;
        St_WD    = 32'h77;
        St_PC    = 32'h0000_0777;
        #1;
        check_eq("t5_full_merge_ready", 32'(St_Ready), 32'd1);
        tick();
        St_Valid = 1'b0;
        Ld_Addr  = 32'h4C;
        #1;
        check_eq("t5_full_merge_count", 32'(Count), 32'd4);
        check_eq("t5_full_merge_data", Ld_Data, 32'h77);
        Dm_Busy = 1'b0;
        tick();
        tick();
        tick();
        #1;
        check_eq("t5_last_addr", Dm_Addr, 32'h4C);
        check_eq("t5_last_wd", Dm_WD, 32'h77);
        check_eq("t5_last_pc", Dm_PC, 32'h0000_0777);
        tick();
        check_eq("t5_drained", 32'(Empty), 32'd1);

        // 5c: same word as a lone entry being retired becomes a new entry
        store(32'h50, 32'h1);
        St_Valid = 1'b1;
        St_Addr  = 32'h50;
        St_WD    = 32'h2;
        #1;
        check_eq("t5c_dm_wd_first", Dm_WD, 32'h1);
        tick();
        St_Valid = 1'b0;
        #1;
        check_eq("t5c_count_push_pop", 32'(Count), 32'd1);
        check_eq("t5c_dm_wd_second", Dm_WD, 32'h2);
        tick();
        check_eq("t5c_empty", 32'(Empty), 32'd1);

        // 6: asynchronous reset mid-cycle while retiring
        Dm_Busy = 1'b1;
        store(32'h60, 32'h61);
        store(32'h64, 32'h62);
        store(32'h68, 32'h63);
        check_eq("t6_count3", 32'(Count), 32'd3);
        Dm_Busy = 1'b0;
        #1;
        check_eq("t6_retiring", 32'(Dm_WE), 32'd1);
        Reset = 1'b0;
        #1;
        check_eq("t6_async_dm_we", 32'(Dm_WE), 32'd0);
        check_eq("t6_async_count", 32'(Count), 32'd0);
        check_eq("t6_async_dm_addr", Dm_Addr, 32'd0);
        #1;
        Reset = 1'b1;
        tick();
        check_eq("t6_no_stale_we", 32'(Dm_WE), 32'd0);
        check_eq("t6_no_stale_empty", 32'(Empty), 32'd1);
        Ld_Addr = 32'h64;
        #1;
        check_eq("t6_no_stale_hit", 32'(Ld_Hit), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
